// File: rtl/cp_multi_dispatcher.sv
// Coprocessor dispatcher: decodes ID/EX instructions, routes each one to one of CP_NUM
// valid/ready channels, tracks the single outstanding op with a timeout, and writes results back.
module cp_multi_dispatcher #(
  parameter int DATA_WIDTH     = 64,
  parameter int INST_WIDTH     = 32,
  parameter int CP_NUM         = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [INST_WIDTH-1:0]          inst,
  input  logic                           inst_valid,
  input  logic [DATA_WIDTH-1:0]          rs1_data,
  input  logic [DATA_WIDTH-1:0]          rs2_data,
  input  logic                           pipeline_stall,
  input  logic                           flush,
  output logic                           cp_detected,
  output logic                           stall_req,
  output logic [CP_NUM-1:0]              cp_req_valid,
  input  logic [CP_NUM-1:0]              cp_req_ready,
  output logic [INST_WIDTH-1:0]          cp_instruction,
  output logic [DATA_WIDTH-1:0]          cp_operand_a,
  output logic [DATA_WIDTH-1:0]          cp_operand_b,
  input  logic [CP_NUM-1:0]              cp_resp_valid,
  input  logic [CP_NUM*DATA_WIDTH-1:0]   cp_resp_data,
  input  logic [CP_NUM-1:0]              cp_resp_exception,
  output logic                           wb_valid,
  output logic [4:0]                     wb_addr,
  output logic [DATA_WIDTH-1:0]          wb_data,
  output logic                           exc_valid,
  output logic [1:0]                     exc_cause,
  output logic                           spurious_resp,
  output logic [CP_NUM*CNT_WIDTH-1:0]    cp_op_count
);

  localparam int              TW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]   TMAX  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      NUM3  = 3'(CP_NUM);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_EXC} state_t;

  state_t                  r_state, w_next;
  logic [INST_WIDTH-1:0]   r_inst;
  logic [DATA_WIDTH-1:0]   r_op_a, r_op_b, r_data;
  logic [1:0]              r_ch, r_cause, w_cause;
  logic                    r_wb_en, r_abort, r_spurious;
  logic [TW-1:0]           r_tcnt;
  logic [CNT_WIDTH-1:0]    r_cnt [CP_NUM];

  logic [1:0]              w_dec_ch;
  logic                    w_dec_hit, w_dec_wb_en, w_accept;
  logic [CP_NUM-1:0]       w_onehot;
  logic [DATA_WIDTH-1:0]   w_resp_data;
  logic                    w_ready, w_resp_hit, w_resp_exc, w_timeout, w_abort, w_spur_hit;

  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_ch  = 2'd0;
    case (inst[6:0])
      7'b1110011: begin w_dec_hit = (inst[14:12] != 3'd0); w_dec_ch = 2'd0; end
      7'b1010011, 7'b0000111, 7'b0100111: begin w_dec_hit = 1'b1; w_dec_ch = 2'd1; end
      7'b0001011: begin w_dec_hit = 1'b1; w_dec_ch = 2'd2; end
      7'b0101011: begin w_dec_hit = 1'b1; w_dec_ch = 2'd3; end
      default: ;
    endcase
  end

  assign cp_detected = w_dec_hit && ({1'b0, w_dec_ch} < NUM3);
  assign w_dec_wb_en = (w_dec_ch != 2'd1) && (inst[11:7] != 5'd0);
  assign w_accept    = inst_valid && cp_detected && !pipeline_stall && !flush;

  always_comb begin
    w_onehot    = '0;
    w_resp_data = '0;
    for (int i = 0; i < CP_NUM; i++) begin
      if (r_ch == 2'(i)) begin
        w_onehot[i] = 1'b1;
        w_resp_data = cp_resp_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_ready    = |(cp_req_ready & w_onehot);
  assign w_resp_hit = |(cp_resp_valid & w_onehot);
  assign w_resp_exc = |(cp_resp_exception & w_onehot);
  assign w_timeout  = (r_tcnt == TMAX);
  assign w_abort    = r_abort || flush;
  assign w_spur_hit = (r_state == S_IDLE) ? |cp_resp_valid : |(cp_resp_valid & ~w_onehot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A handshake or response in the timeout cycle takes priority over the timeout.
  always_comb begin
    w_next  = r_state;
    w_cause = 2'd0;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: begin
        if (flush)          w_next = S_IDLE;
        else if (w_ready)   w_next = S_WAIT;
        else if (w_timeout) begin w_next = S_EXC; w_cause = 2'd2; end
      end
      S_WAIT: begin
        if (w_resp_hit) begin
          if (w_abort)         w_next = S_IDLE;
          else if (w_resp_exc) begin w_next = S_EXC; w_cause = 2'd1; end
          else                 w_next = S_DONE;
        end else if (w_timeout) begin
          if (w_abort) w_next = S_IDLE;
          else begin w_next = S_EXC; w_cause = 2'd2; end
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_EXC:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst     <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_data     <= '0;
      r_ch       <= 2'd0;
      r_wb_en    <= 1'b0;
      r_abort    <= 1'b0;
      r_cause    <= 2'd0;
      r_tcnt     <= '0;
      r_spurious <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_inst  <= inst;
        r_op_a  <= rs1_data;
        r_op_b  <= rs2_data;
        r_ch    <= w_dec_ch;
        r_wb_en <= w_dec_wb_en;
        r_abort <= 1'b0;
        r_tcnt  <= '0;
      end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
      if (r_state == S_WAIT && flush)      r_abort <= 1'b1;
      if (r_state == S_WAIT && w_resp_hit) r_data  <= w_resp_data;
      if (w_next == S_EXC)                 r_cause <= w_cause;
      if (w_spur_hit)                      r_spurious <= 1'b1;
    end
  end

  // Completion counters only advance in DONE, so aborted and excepting ops never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CP_NUM; i++) r_cnt[i] <= '0;
    end else if (r_state == S_DONE) begin
      for (int i = 0; i < CP_NUM; i++)
        if (r_ch == 2'(i) && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
    end
  end

  for (genvar g = 0; g < CP_NUM; g++) begin : g_cnt
    assign cp_op_count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt[g];
  end

  assign stall_req      = (r_state == S_IDLE && inst_valid && cp_detected) ||
                          (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign cp_req_valid   = (r_state == S_ISSUE && !flush) ? w_onehot : '0;
  assign cp_instruction = r_inst;
  assign cp_operand_a   = r_op_a;
  assign cp_operand_b   = r_op_b;
  assign wb_valid       = (r_state == S_DONE) && r_wb_en;
  assign wb_addr        = r_inst[11:7];
  assign wb_data        = r_data;
  assign exc_valid      = (r_state == S_EXC);
  assign exc_cause      = r_cause;
  assign spurious_resp  = r_spurious;

endmodule

// File: tb/tb_cp_multi_dispatcher.sv
// Scoreboard bench for cp_multi_dispatcher: stimulus queues the expected strobes,
// a negedge monitor pops and compares every wb/exc strobe the DUT presents.
module tb_cp_multi_dispatcher;

  localparam int DW   = 64;
  localparam int NCH  = 4;
  localparam int CNTW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       inst = '0;
  logic              inst_valid = 1'b0;
  logic [DW-1:0]     rs1_data = '0, rs2_data = '0;
  logic              pipeline_stall = 1'b0, flush = 1'b0;
  logic              cp_detected, stall_req;
  logic [NCH-1:0]    cp_req_valid;
  logic [NCH-1:0]    cp_req_ready = '0;
  logic [31:0]       cp_instruction;
  logic [DW-1:0]     cp_operand_a, cp_operand_b;
  logic [NCH-1:0]    cp_resp_valid = '0;
  logic [NCH*DW-1:0] cp_resp_data = '0;
  logic [NCH-1:0]    cp_resp_exception = '0;
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic [DW-1:0]     wb_data;
  logic              exc_valid;
  logic [1:0]        exc_cause;
  logic              spurious_resp;
  logic [NCH*CNTW-1:0] cp_op_count;

  // Second instance with only two channels, used for decode-range checks.
  logic [31:0]       d2_inst = '0;
  logic              d2_inst_valid = 1'b0;
  logic              d2_pipeline_stall = 1'b1;
  logic              d2_cp_detected, d2_stall_req;
  logic [1:0]        d2_cp_req_valid;
  logic [31:0]       d2_cp_instruction;
  logic [DW-1:0]     d2_cp_operand_a, d2_cp_operand_b, d2_wb_data;
  logic [4:0]        d2_wb_addr;
  logic              d2_wb_valid, d2_exc_valid, d2_spurious_resp;
  logic [1:0]        d2_exc_cause;
  logic [2*16-1:0]   d2_cp_op_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        isExc;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [1:0]  cause;
  } exp_t;
  exp_t expQ[$];

  cp_multi_dispatcher #(.DATA_WIDTH(DW), .INST_WIDTH(32), .CP_NUM(NCH),
                        .TIMEOUT_CYCLES(8), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pipeline_stall(pipeline_stall),
    .flush(flush), .cp_detected(cp_detected), .stall_req(stall_req),
    .cp_req_valid(cp_req_valid), .cp_req_ready(cp_req_ready),
    .cp_instruction(cp_instruction), .cp_operand_a(cp_operand_a),
    .cp_operand_b(cp_operand_b), .cp_resp_valid(cp_resp_valid),
    .cp_resp_data(cp_resp_data), .cp_resp_exception(cp_resp_exception),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause),
    .spurious_resp(spurious_resp), .cp_op_count(cp_op_count)
  );

  cp_multi_dispatcher #(.DATA_WIDTH(DW), .INST_WIDTH(32), .CP_NUM(2),
                        .TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .inst(d2_inst), .inst_valid(d2_inst_valid),
    .rs1_data('0), .rs2_data('0), .pipeline_stall(d2_pipeline_stall),
    .flush(1'b0), .cp_detected(d2_cp_detected), .stall_req(d2_stall_req),
    .cp_req_valid(d2_cp_req_valid), .cp_req_ready(2'b00),
    .cp_instruction(d2_cp_instruction), .cp_operand_a(d2_cp_operand_a),
    .cp_operand_b(d2_cp_operand_b), .cp_resp_valid(2'b00),
    .cp_resp_data('0), .cp_resp_exception(2'b00),
    .wb_valid(d2_wb_valid), .wb_addr(d2_wb_addr), .wb_data(d2_wb_data),
    .exc_valid(d2_exc_valid), .exc_cause(d2_exc_cause),
    .spurious_resp(d2_spurious_resp), .cp_op_count(d2_cp_op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNTW-1:0] cnt(input int ch);
    return cp_op_count[ch*CNTW +: CNTW];
  endfunction

  task automatic expectWb(input logic [4:0] addr, input logic [63:0] data);
    expQ.push_back('{isExc: 1'b0, addr: addr, data: data, cause: 2'd0});
  endtask

  task automatic expectExc(input logic [1:0] cause);
    expQ.push_back('{isExc: 1'b1, addr: 5'd0, data: 64'd0, cause: cause});
  endtask

  // Monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || exc_valid)) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_strobe: got wb=%0b exc=%0b, expected no strobe", wb_valid, exc_valid);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("strobe_kind", {62'd0, wb_valid, exc_valid}, e.isExc ? 64'd1 : 64'd2);
        if (e.isExc) begin
          checkOutput("exc_cause", {62'd0, exc_cause}, {62'd0, e.cause});
        end else begin
          checkOutput("wb_addr", {59'd0, wb_addr}, {59'd0, e.addr});
          checkOutput("wb_data", wb_data, e.data);
        end
      end
    end
  end

  // Full transaction: accept, hold request readyDelay cycles, respond respDelay cycles later.
  task automatic applyStimulus(input logic [31:0] iInst, input int ch, input int readyDelay,
                               input int respDelay, input logic [63:0] data, input logic excFlag,
                               output int reqCycles, output int stallCycles);
    logic [63:0] a, b;
    reqCycles = 0;
    stallCycles = 0;
    a = {32'hA5A5A5A5, iInst};
    b = {iInst, 32'h5A5A5A5A};
    inst = iInst; inst_valid = 1'b1; rs1_data = a; rs2_data = b;
    @(negedge clk);
    if (stall_req) stallCycles++;
    tick();
    inst_valid = 1'b0; rs1_data = '0; rs2_data = '0;
    for (int k = 0; k <= readyDelay; k++) begin
      if (k == readyDelay) cp_req_ready[ch] = 1'b1;
      @(negedge clk);
      if (k == 0) begin
        checkOutput("cp_instruction", {32'd0, cp_instruction}, {32'd0, iInst});
        checkOutput("cp_operand_a", cp_operand_a, a);
        checkOutput("cp_operand_b", cp_operand_b, b);
      end
      if (cp_req_valid[ch]) reqCycles++;
      if (stall_req) stallCycles++;
      tick();
      cp_req_ready = '0;
    end
    for (int k = 0; k <= respDelay; k++) begin
      if (k == respDelay) begin
        cp_resp_valid[ch] = 1'b1;
        cp_resp_exception[ch] = excFlag;
        cp_resp_data[ch*DW +: DW] = data;
      end
      @(negedge clk);
      if (stall_req) stallCycles++;
      tick();
      cp_resp_valid = '0; cp_resp_exception = '0; cp_resp_data = '0;
    end
    @(negedge clk);
    if (stall_req) stallCycles++;
    tick();
  endtask

  initial begin
    int rq, st, excAt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    checkOutput("reset_req_valid", {60'd0, cp_req_valid}, 64'd0);
    checkOutput("reset_stall", {63'd0, stall_req}, 64'd0);
    checkOutput("reset_strobes", {62'd0, wb_valid, exc_valid}, 64'd0);
    checkOutput("reset_spurious", {63'd0, spurious_resp}, 64'd0);
    checkOutput("reset_counts", {56'd0, cp_op_count}, 64'd0);

    // Decode only (inst_valid low, nothing accepted).
    tick();
    inst = 32'h0000_0073; #1;
    checkOutput("decode_ecall", {63'd0, cp_detected}, 64'd0);
    inst = 32'h0000_10F3; #1;
    checkOutput("decode_csr", {63'd0, cp_detected}, 64'd1);
    inst = 32'h0000_0027; #1;
    checkOutput("decode_fsw", {63'd0, cp_detected}, 64'd1);

    // Flush in IDLE blocks acceptance.
    inst = 32'h0000_028B; inst_valid = 1'b1; flush = 1'b1;
    tick();
    inst_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle_no_issue", {60'd0, cp_req_valid}, 64'd0);
    tick();

    // Minimum-latency CUSTOM-0 on ch2, rd=5.
    expectWb(5'd5, 64'h0000_0000_DEAD_BEEF);
    applyStimulus(32'h0000_028B, 2, 0, 0, 64'h0000_0000_DEAD_BEEF, 1'b0, rq, st);
    checkOutput("t1_req_cycles", 64'(rq), 64'd1);
    checkOutput("t1_stall_cycles", 64'(st), 64'd3);
    checkOutput("t1_count2", {62'd0, cnt(2)}, 64'd1);

    // FP op on ch1: ready after 3 extra cycles, no writeback.
    applyStimulus(32'h0000_01D3, 1, 3, 2, 64'h1234_5678, 1'b0, rq, st);
    checkOutput("t2_req_cycles", 64'(rq), 64'd4);
    checkOutput("t2_stall_cycles", 64'(st), 64'd8);
    checkOutput("t2_count1", {62'd0, cnt(1)}, 64'd1);
    checkOutput("t2_spurious_clear", {63'd0, spurious_resp}, 64'd0);

    // CSR op on ch0 that never gets ready: timeout; ch2 pulse while ch0 active.
    expectExc(2'd2);
    inst = 32'h0000_10F3; inst_valid = 1'b1;
    @(negedge clk);
    tick();
    inst_valid = 1'b0;
    excAt = -1;
    for (int k = 1; k <= 15; k++) begin
      cp_resp_valid = (k == 3) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (exc_valid) begin
        excAt = k;
        tick();
        break;
      end
      tick();
    end
    cp_resp_valid = '0;
    checkOutput("t3_timeout_cycle", 64'(excAt), 64'd9);
    checkOutput("t3_spurious_set", {63'd0, spurious_resp}, 64'd1);
    checkOutput("t3_count0", {62'd0, cnt(0)}, 64'd0);

    // ch3 response with exception flag.
    expectExc(2'd1);
    applyStimulus(32'h0000_03AB, 3, 0, 0, 64'hCAFE, 1'b1, rq, st);
    checkOutput("t4_count3", {62'd0, cnt(3)}, 64'd0);

    // Flush while waiting; late response must be discarded.
    inst = 32'h0000_048B; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0; cp_req_ready = 4'b0100;
    tick();
    cp_req_ready = '0; flush = 1'b1;
    @(negedge clk);
    checkOutput("t5_wait_stall", {63'd0, stall_req}, 64'd1);
    tick();
    flush = 1'b0; cp_resp_valid = 4'b0100; cp_resp_data[2*DW +: DW] = 64'h77;
    @(negedge clk);
    checkOutput("t5_still_waiting", {63'd0, stall_req}, 64'd1);
    tick();
    cp_resp_valid = '0; cp_resp_data = '0;
    @(negedge clk);
    checkOutput("t5_back_idle", {63'd0, stall_req}, 64'd0);
    checkOutput("t5_count2", {62'd0, cnt(2)}, 64'd1);
    tick();

    // Flush in ISSUE drops the request in the same cycle.
    inst = 32'h0000_050B; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0; flush = 1'b1; cp_req_ready = 4'b0100;
    @(negedge clk);
    checkOutput("t6_req_dropped", {60'd0, cp_req_valid}, 64'd0);
    tick();
    flush = 1'b0; cp_req_ready = '0;
    @(negedge clk);
    checkOutput("t6_back_idle", {63'd0, stall_req}, 64'd0);
    checkOutput("t6_count2", {62'd0, cnt(2)}, 64'd1);
    tick();

    // Three more ch2 ops: counter saturates at 3.
    expectWb(5'd10, 64'h1234);
    applyStimulus(32'h0000_050B, 2, 0, 0, 64'h1234, 1'b0, rq, st);
    applyStimulus(32'h0000_000B, 2, 0, 0, 64'h55, 1'b0, rq, st);
    checkOutput("t7_count2_pre", {62'd0, cnt(2)}, 64'd3);
    expectWb(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(32'h0000_0F8B, 2, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rq, st);
    checkOutput("t7_count2_sat", {62'd0, cnt(2)}, 64'd3);

    // Two-channel instance: ch2/ch3 opcodes are not detected.
    d2_inst_valid = 1'b1;
    d2_inst = 32'h0000_03AB; #1;
    checkOutput("d2_ch3_detect", {63'd0, d2_cp_detected}, 64'd0);
    checkOutput("d2_ch3_stall", {63'd0, d2_stall_req}, 64'd0);
    d2_inst = 32'h0000_028B; #1;
    checkOutput("d2_ch2_detect", {63'd0, d2_cp_detected}, 64'd0);
    d2_inst = 32'h0000_0187; #1;
    checkOutput("d2_ch1_detect", {63'd0, d2_cp_detected}, 64'd1);
    checkOutput("d2_ch1_stall", {63'd0, d2_stall_req}, 64'd1);
    d2_inst_valid = 1'b0;

    // Asynchronous reset mid-operation.
    inst = 32'h0000_028B; inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    @(negedge clk);
    checkOutput("t8_req_before_reset", {60'd0, cp_req_valid}, 64'd4);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t8_req_async_drop", {60'd0, cp_req_valid}, 64'd0);
    checkOutput("t8_counts_cleared", {56'd0, cp_op_count}, 64'd0);
    checkOutput("t8_spurious_cleared", {63'd0, spurious_resp}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
